// File: rtl/led_blink_sched.sv
// Round-robin scheduler sharing one LED between NREQ blink-burst requesters.
// Optional LED_PRIO_EN: requester 0 wins every arbitration it takes part in.
module led_blink_sched #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 32,
  parameter int BLK_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] period,
  input  logic [NREQ*CNT_W-1:0] on_time,
  input  logic [NREQ*BLK_W-1:0] blinks,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  led
);

  // state | meaning
  // IDLE  | no owner, arbitrating among active requests
  // RUN   | owner's burst in progress, counters advancing
  // DONE  | single cycle, done pulse on owner's bit
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int IDX_W = $clog2(NREQ);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  owner, ptr, win_idx, scan_idx;
  logic              win_vld;
  logic [CNT_W-1:0]  cnt, pm1_l, on_time_l;
  logic [BLK_W-1:0]  bcnt, blinks_l;
  logic [CNT_W-1:0]  per_sel, on_sel;
  logic [BLK_W-1:0]  blk_sel;
  logic              cnt_wrap, burst_end, abort;

  assign per_sel = period[win_idx*CNT_W +: CNT_W];
  assign on_sel  = on_time[win_idx*CNT_W +: CNT_W];
  assign blk_sel = blinks[win_idx*BLK_W +: BLK_W];

  // Search starts one past the last owner and wraps.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = IDX_W'((int'(ptr) + k) % NREQ);
      if (!win_vld && req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
`ifdef LED_PRIO_EN
    if (req[0]) begin
      win_vld = 1'b1;
      win_idx = '0;
    end
`endif
  end

  assign cnt_wrap  = (cnt == pm1_l);
  assign burst_end = (blinks_l == '0) || (cnt_wrap && (bcnt == blinks_l - BLK_W'(1)));
  assign abort     = !req[owner];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_vld) state_nxt = RUN;
      RUN: begin
        if (abort)          state_nxt = IDLE;
        else if (burst_end) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant     <= '0;
      led       <= 1'b0;
      owner     <= '0;
      ptr       <= IDX_W'(NREQ - 1);
      cnt       <= '0;
      bcnt      <= '0;
      pm1_l     <= '0;
      on_time_l <= '0;
      blinks_l  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          led <= 1'b0;
          if (win_vld) begin
            owner     <= win_idx;
            grant     <= NREQ'(1) << win_idx;
            pm1_l     <= (per_sel == '0) ? '0 : per_sel - CNT_W'(1);
            on_time_l <= on_sel;
            blinks_l  <= blk_sel;
            cnt       <= '0;
            bcnt      <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            led   <= 1'b0;
            grant <= '0;
            ptr   <= owner;
          end else if (burst_end) begin
            led <= 1'b0;
          end else begin
            // led is the registered image of the current count position
            led  <= (cnt < on_time_l);
            cnt  <= cnt_wrap ? '0 : cnt + CNT_W'(1);
            bcnt <= cnt_wrap ? bcnt + BLK_W'(1) : bcnt;
          end
        end
        DONE: begin
          led   <= 1'b0;
          grant <= '0;
          ptr   <= owner;
        end
        default: led <= 1'b0;
      endcase
    end
  end

  assign done = (state == DONE) ? grant : '0;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_led_blink_sched.sv
// Directed bench for led_blink_sched: table of single-owner bursts plus
// hand-written sequences for round-robin order, abort, reset and priority.
module tb_led_blink_sched;

  localparam int NREQ  = 4;
  localparam int CNT_W = 32;
  localparam int BLK_W = 8;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] period, on_time;
  logic [NREQ*BLK_W-1:0] blinks;
  logic [NREQ-1:0]       grant, done;
  logic                  busy, led;

  int n_cmp = 0;
  int n_err = 0;

  led_blink_sched #(.NREQ(NREQ), .CNT_W(CNT_W), .BLK_W(BLK_W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .period(period), .on_time(on_time),
    .blinks(blinks), .grant(grant), .done(done), .busy(busy), .led(led)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          id;
    logic [31:0] p;
    logic [31:0] o;
    logic [7:0]  b;
    int          done_cyc;
    logic [15:0] led_exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_cfg(input int i, input logic [31:0] p, input logic [31:0] o, input logic [7:0] b);
    period[i*CNT_W +: CNT_W]  = p;
    on_time[i*CNT_W +: CNT_W] = o;
    blinks[i*BLK_W +: BLK_W]  = b;
  endtask

  task automatic do_reset();
    req = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] g);
    int n = 0;
    while (grant == '0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    g = grant;
    if (grant == '0) begin
      n_cmp++; n_err++;
      $display("FAIL wait_grant timeout actual=0 required=nonzero");
    end
  endtask

  task automatic wait_done(output logic [NREQ-1:0] d);
    int n = 0;
    while (done == '0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    d = done;
    if (done == '0) begin
      n_cmp++; n_err++;
      $display("FAIL wait_done timeout actual=0 required=nonzero");
    end
  endtask

  initial begin
    logic [NREQ-1:0] g, d, onehot;
    logic [NREQ-1:0] t2exp [5];
    logic            seen_done;

    // id, period, on_time, blinks, edges grant->DONE, led per edge (bit0 = first edge)
    vecs[0] = '{1, 32'd4, 32'd2, 8'd2, 8, 16'h0033};
    vecs[1] = '{2, 32'd4, 32'd2, 8'd0, 1, 16'h0000};
    vecs[2] = '{3, 32'd3, 32'd5, 8'd2, 6, 16'h001F};
    vecs[3] = '{0, 32'd3, 32'd0, 8'd2, 6, 16'h0000};
    vecs[4] = '{1, 32'd0, 32'd1, 8'd3, 3, 16'h0003};
    vecs[5] = '{2, 32'd5, 32'd3, 8'd1, 5, 16'h0007};
    vecs[6] = '{0, 32'd2, 32'd1, 8'd1, 2, 16'h0001};
    t2exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    req = '0; period = '0; on_time = '0; blinks = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_led", led, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Priority scenario: 1 running, 2 waiting, 0 arrives mid-burst
    for (int i = 0; i < NREQ; i++) set_cfg(i, 32'd2, 32'd1, 8'd1);
    @(negedge clk);
    req = 4'b0110;
    @(posedge clk); #1;
    chk("t6_first", grant, 4'b0010);
    @(negedge clk);
    req = 4'b0111;
    wait_done(d);
    chk("t6_done", d, 4'b0010);
    @(posedge clk); #1;
    chk("t6_idle", grant, 0);
    wait_grant(g);
`ifdef LED_PRIO_EN
    chk("t6_next", g, 4'b0001);
`else
    chk("t6_next", g, 4'b0100);
`endif
    do_reset();

    // Table of single-owner bursts
    for (int v = 0; v < 7; v++) begin
      onehot = '0;
      onehot[vecs[v].id] = 1'b1;
      set_cfg(vecs[v].id, vecs[v].p, vecs[v].o, vecs[v].b);
      req = onehot;
      @(posedge clk); #1;
      chk("vec_grant", grant, onehot);
      chk("vec_busy", busy, 1);
      @(negedge clk);
      set_cfg(vecs[v].id, 32'd7, 32'd0, 8'd9);
      for (int k = 1; k <= vecs[v].done_cyc; k++) begin
        if (k > 1) @(negedge clk);
        @(posedge clk); #1;
        chk("vec_led", led, vecs[v].led_exp[k-1]);
        chk("vec_done", done, (k == vecs[v].done_cyc) ? onehot : '0);
      end
      @(negedge clk);
      req = '0;
      @(posedge clk); #1;
      chk("vec_end_grant", grant, 0);
      chk("vec_end_done", done, 0);
      chk("vec_end_busy", busy, 0);
      @(negedge clk);
    end

    // Round-robin with all requesters held
    do_reset();
    for (int i = 0; i < NREQ; i++) set_cfg(i, 32'd2, 32'd1, 8'd1);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_grant(g);
      chk("t2_grant", g, t2exp[t]);
      wait_done(d);
      chk("t2_done", d, t2exp[t]);
      @(posedge clk); #1;
      chk("t2_done_clr", done, 0);
      chk("t2_gap", grant, 0);
      if (t < 4) begin
        @(posedge clk); #1;
        chk("t2_next", grant, t2exp[t+1]);
      end
    end
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);

    // Abort: owner 1 drops request mid-burst
    set_cfg(1, 32'd4, 32'd2, 8'd3);
    set_cfg(2, 32'd2, 32'd1, 8'd1);
    req = 4'b0010;
    @(posedge clk); #1;
    chk("ab_grant", grant, 4'b0010);
    repeat (2) @(posedge clk);
    #1;
    chk("ab_led_on", led, 1);
    @(negedge clk);
    req = '0;
    @(posedge clk); #1;
    chk("ab_grant_clr", grant, 0);
    chk("ab_led", led, 0);
    chk("ab_busy", busy, 0);
    seen_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done != '0) seen_done = 1'b1;
    end
    chk("ab_no_done", seen_done, 0);
    @(negedge clk);
    req = 4'b0110;
    @(posedge clk); #1;
    chk("ab_ptr", grant, 4'b0100);
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-burst
    set_cfg(3, 32'd4, 32'd4, 8'd5);
    req = 4'b1000;
    repeat (3) @(posedge clk);
    #1;
    chk("rr_led_pre", led, 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rr_grant", grant, 0);
    chk("rr_led", led, 0);
    chk("rr_busy", busy, 0);
    chk("rr_done", done, 0);
    req = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rr_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
